// File: rtl/bcam_pkg.sv
// Shared BCAM definitions: geometry defaults and the search-controller state encoding.
package bcam_pkg;

  localparam int unsigned BCAM_WIDTH  = 8;   // key bits per row
  localparam int unsigned BCAM_DEPTH  = 16;  // rows / match lines
  localparam int unsigned BCAM_ADDR_W = 4;   // clog2(BCAM_DEPTH)

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_EMIT    = 2'd3
  } bcam_state_e;

endpackage : bcam_pkg

// File: rtl/bcam_prio_enc.sv
// Lowest-set-bit priority encoder over the pending match vector.
//   vec             : match vector to encode
//   idx             : index of the lowest set bit (0 when vec is empty)
//   any             : at least one bit set
//   one_hot_or_zero : at most one bit set (the current beat is the final one)
module bcam_prio_enc
  import bcam_pkg::*;
#(
  parameter int unsigned DEPTH  = BCAM_DEPTH,
  parameter int unsigned ADDR_W = BCAM_ADDR_W
) (
  input  logic [DEPTH-1:0]  vec,
  output logic [ADDR_W-1:0] idx,
  output logic              any,
  output logic              one_hot_or_zero
);

  // Scan from the top down so the lowest set index wins.
  always_comb begin
    idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (vec[i]) idx = ADDR_W'(i);
    end
  end

  assign any             = |vec;
  // Clearing the lowest set bit leaves zero only if at most one bit was set.
  assign one_hot_or_zero = ((vec & (vec - DEPTH'(1))) == '0);

endmodule : bcam_prio_enc

// File: rtl/bcam_match_resolver.sv
// Search-side BCAM controller: accepts a lookup key, fires one search cycle
// into the array, captures the match lines and streams every matching row
// address (lowest first) on a valid/ready result channel. An empty match
// produces a single miss beat.
//   clk, rst                 : clock, synchronous active-high reset
//   abort                    : drop the current lookup, return to IDLE
//   req_valid/req_ready/key  : lookup request handshake
//   cam_search_en/key        : one-cycle search strobe and key to the array
//   cam_match_vec            : per-row match lines, valid the cycle after the strobe
//   res_valid/res_ready      : result beat handshake
//   res_addr/res_hit/res_last: matching row, hit flag, final-beat flag
module bcam_match_resolver
  import bcam_pkg::*;
#(
  parameter int unsigned WIDTH  = BCAM_WIDTH,
  parameter int unsigned DEPTH  = BCAM_DEPTH,
  parameter int unsigned ADDR_W = BCAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic              req_valid,
  input  logic [WIDTH-1:0]  req_key,
  output logic              req_ready,
  output logic              cam_search_en,
  output logic [WIDTH-1:0]  cam_search_key,
  input  logic [DEPTH-1:0]  cam_match_vec,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ADDR_W-1:0] res_addr,
  output logic              res_hit,
  output logic              res_last
);

  bcam_state_e      state_q, state_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic [DEPTH-1:0] pend_q, pend_d;

  logic [ADDR_W-1:0] enc_idx;
  logic              enc_any;
  logic              enc_last;

  bcam_prio_enc #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_prio_enc (
    .vec            (pend_q),
    .idx            (enc_idx),
    .any            (enc_any),
    .one_hot_or_zero(enc_last)
  );

  // State, key and pending-match registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state and output decode; result outputs are combinational so a
  // beat can be consumed every cycle.
  always_comb begin
    state_d        = state_q;
    key_d          = key_q;
    pend_d         = pend_q;
    req_ready      = 1'b0;
    cam_search_en  = 1'b0;
    cam_search_key = '0;
    res_valid      = 1'b0;
    res_addr       = '0;
    res_hit        = 1'b0;
    res_last       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = !abort;
        if (req_valid && !abort) begin
          key_d   = req_key;
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        cam_search_en  = 1'b1;
        cam_search_key = key_q;
        state_d        = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        cam_search_key = key_q;
        pend_d         = cam_match_vec;
        state_d        = ST_EMIT;
      end
      ST_EMIT: begin
        res_valid = 1'b1;
        res_hit   = enc_any;
        res_addr  = enc_idx;
        res_last  = enc_last;
        if (res_ready) begin
          // Retire the reported row; a miss beat clears nothing.
          pend_d = pend_q & ~(DEPTH'(1) << enc_idx);
          if (enc_last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything; the search strobe above still fires.
    if (abort) begin
      state_d = ST_IDLE;
      pend_d  = '0;
    end
  end

endmodule : bcam_match_resolver

// File: tb/tb_bcam_match_resolver.sv
// Self-checking bench for bcam_match_resolver with a one-cycle CAM stub.
module tb_bcam_match_resolver;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              abort = 1'b0;
  logic              req_valid = 1'b0;
  logic [WIDTH-1:0]  req_key = '0;
  logic              req_ready;
  logic              cam_search_en;
  logic [WIDTH-1:0]  cam_search_key;
  logic [DEPTH-1:0]  cam_match_vec = '0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [ADDR_W-1:0] res_addr;
  logic              res_hit;
  logic              res_last;

  logic [DEPTH-1:0]  prog_vec = '0;
  int                vectors = 0;
  int                miscompares = 0;

  always #5 clk = ~clk;

  bcam_match_resolver #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .abort(abort),
    .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
    .cam_search_en(cam_search_en), .cam_search_key(cam_search_key),
    .cam_match_vec(cam_match_vec),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_addr(res_addr), .res_hit(res_hit), .res_last(res_last)
  );

  // CAM stub: programmed vector one cycle after the strobe, noise otherwise.
  always @(posedge clk) begin
    if (cam_search_en) cam_match_vec <= prog_vec;
    else               cam_match_vec <= DEPTH'($urandom);
  end

  // Full lookup against a reference built from the vector's set bits.
  // abort_beat >= 0 asserts abort together with that beat's handshake.
  task automatic run_lookup(input logic [WIDTH-1:0] key, input logic [DEPTH-1:0] vec,
                            input int first_stall, input int stall_pct, input int abort_beat);
    int exp_q[$];
    int nb, b, cyc, stall, wait_c;
    logic exp_hit;
    for (int i = 0; i < int'(DEPTH); i++) if (vec[i]) exp_q.push_back(i);
    exp_hit = (exp_q.size() != 0);
    if (!exp_hit) exp_q.push_back(0);
    nb = (abort_beat >= 0 && abort_beat < exp_q.size()) ? abort_beat + 1 : exp_q.size();
    prog_vec = vec;

    @(negedge clk); req_valid = 1'b1; req_key = key; res_ready = 1'b0; #1;
    wait_c = 0;
    while (!req_ready && wait_c < 20) begin @(negedge clk); #1; wait_c++; end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL req_ready_accept: got %b want 1", req_ready);
    end

    @(negedge clk); req_valid = 1'b0; req_key = WIDTH'($urandom); #1;
    vectors++;
    if (cam_search_en !== 1'b1 || cam_search_key !== key || res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL search_strobe: en=%b key=%h valid=%b want en=1 key=%h valid=0",
               cam_search_en, cam_search_key, res_valid, key);
    end

    @(negedge clk); #1;
    vectors++;
    if (cam_search_en !== 1'b0 || cam_search_key !== key || res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL capture_cycle: en=%b key=%h valid=%b want en=0 key=%h valid=0",
               cam_search_en, cam_search_key, res_valid, key);
    end

    b = 0; cyc = 0; stall = first_stall;
    while (b < nb && cyc < 200) begin
      @(negedge clk);
      if (stall > 0) begin res_ready = 1'b0; stall--; end
      else res_ready = ($urandom_range(99) >= stall_pct);
      if (b == abort_beat) begin res_ready = 1'b1; abort = 1'b1; end
      #1;
      vectors++;
      if (res_valid !== 1'b1 || res_addr !== ADDR_W'(exp_q[b]) || res_hit !== exp_hit ||
          res_last !== (b == exp_q.size() - 1)) begin
        miscompares++;
        $display("FAIL beat%0d: valid=%b addr=%0d hit=%b last=%b want 1 %0d %b %b",
                 b, res_valid, res_addr, res_hit, res_last, exp_q[b], exp_hit,
                 (b == exp_q.size() - 1));
      end
      if (res_ready) b++;
      cyc++;
    end
    if (b < nb) begin
      vectors++; miscompares++;
      $display("FAIL beat_timeout: got %0d beats want %0d", b, nb);
    end

    @(negedge clk); res_ready = 1'b0; abort = 1'b0; #1;
    vectors++;
    if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL post_lookup: valid=%b ready=%b want 0 1", res_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; #1;
    vectors++;
    if (cam_search_en !== 1'b0 || cam_search_key !== '0 || res_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: en=%b key=%h valid=%b ready=%b want 0 00 0 1",
               cam_search_en, cam_search_key, res_valid, req_ready);
    end
  endtask

  task automatic test_single_hit();  run_lookup(8'hA5, 16'h0010, 0, 0, -1); endtask
  task automatic test_multi_hit();   run_lookup(8'h3C, 16'h8005, 0, 0, -1); endtask
  task automatic test_miss();        run_lookup(8'h00, 16'h0000, 0, 0, -1); endtask
  task automatic test_stall();       run_lookup(8'h5A, 16'h0006, 3, 0, -1); endtask
  task automatic test_all_match();   run_lookup(8'hFF, 16'hFFFF, 0, 0, -1); endtask
  task automatic test_abort_emit();
    run_lookup(8'h77, 16'hFFFF, 0, 0, 2);
    run_lookup(8'h11, 16'h0100, 0, 0, -1);
  endtask

  task automatic test_abort_idle();
    @(negedge clk); abort = 1'b1; req_valid = 1'b1; req_key = 8'h99; #1;
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++; $display("FAIL abort_idle_ready: got %b want 0", req_ready);
    end
    @(negedge clk); abort = 1'b0; req_valid = 1'b0; #1;
    vectors++;
    if (cam_search_en !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_idle_noaccept: en=%b ready=%b want 0 1", cam_search_en, req_ready);
    end
  endtask

  task automatic test_abort_search();
    prog_vec = 16'h0F0F;
    @(negedge clk); req_valid = 1'b1; req_key = 8'h42; #1;
    @(negedge clk); req_valid = 1'b0; abort = 1'b1; #1;
    vectors++;
    if (cam_search_en !== 1'b1 || cam_search_key !== 8'h42) begin
      miscompares++;
      $display("FAIL abort_search_strobe: en=%b key=%h want 1 42", cam_search_en, cam_search_key);
    end
    @(negedge clk); abort = 1'b0; #1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (res_valid !== 1'b0 || req_ready !== 1'b1 || cam_search_key !== '0) begin
        miscompares++;
        $display("FAIL abort_search_idle%0d: valid=%b ready=%b key=%h want 0 1 00",
                 k, res_valid, req_ready, cam_search_key);
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_rst_mid();
    prog_vec = 16'hAAAA;
    @(negedge clk); req_valid = 1'b1; req_key = 8'hC3; #1;
    @(negedge clk); req_valid = 1'b0; #1;
    @(negedge clk); rst = 1'b1; #1;
    @(negedge clk); rst = 1'b0; #1;
    vectors++;
    if (cam_search_en !== 1'b0 || cam_search_key !== '0 || res_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_state: en=%b key=%h valid=%b ready=%b want 0 00 0 1",
               cam_search_en, cam_search_key, res_valid, req_ready);
    end
    run_lookup(8'h1E, 16'h0201, 0, 0, -1);
  endtask

  task automatic test_random();
    logic [DEPTH-1:0] v;
    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(3))
        0:       v = '0;
        1:       v = DEPTH'(1) << $urandom_range(DEPTH - 1);
        default: v = DEPTH'($urandom);
      endcase
      run_lookup(WIDTH'($urandom), v, $urandom_range(2), $urandom_range(60), -1);
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_multi_hit();
    test_miss();
    test_stall();
    test_all_match();
    test_abort_emit();
    test_abort_idle();
    test_abort_search();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_bcam_match_resolver

// File: doc/bcam_match_resolver.md
Name: bcam_match_resolver

Overview:
- Search-side controller for the BCAM array. It accepts a lookup key from a requester and drives one search cycle into the CAM row cells.
- It then reads back the per-row match lines and serialises every matching row address, lowest index first, onto a valid/ready result stream.
- It sits between the lookup client and the BCAM array, and is the consumer of the match chain the cells produce.

Parameters:
- WIDTH, 8, key width in bits (cells per row)
- DEPTH, 16, number of CAM rows (match lines)
- ADDR_W, 4, row address width; must equal clog2(DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- abort  in  1  drop current lookup and return to IDLE
- req_valid  in  1  lookup request present
- req_key  in  WIDTH  key to search
- req_ready  out  1  request accepted when req_valid && req_ready
- cam_search_en  out  1  one-cycle search strobe to array
- cam_search_key  out  WIDTH  key driven to all rows
- cam_match_vec  in  DEPTH  per-row match lines; valid the cycle after cam_search_en
- res_valid  out  1  result beat present
- res_ready  in  1  consumer accepts beat
- res_addr  out  ADDR_W  matching row address
- res_hit  out  1  1 = real match, 0 = miss beat
- res_last  out  1  final beat of this lookup

Behaviour:
- Reset: rst is synchronous, active-high, clock clk. At the reset edge the state goes to IDLE; key_q, pend_q, res_addr, res_hit and res_last are cleared.
- Outputs immediately after the reset edge: cam_search_en=0, cam_search_key=0, res_valid=0, req_ready=1 (if abort=0).
- States: IDLE, SEARCH, CAPTURE, EMIT.
- IDLE:
  - req_ready = !abort.
  - On accept (cycle T): key_q <= req_key, then go to SEARCH.
- SEARCH (T+1):
  - cam_search_en=1 and cam_search_key=key_q for exactly one cycle.
  - Go to CAPTURE.
- CAPTURE (T+2):
  - pend_q <= cam_match_vec.
  - Go to EMIT.
  - cam_search_key holds key_q in SEARCH and CAPTURE; it reads 0 otherwise.
- EMIT (first beat at T+3):
  - res_valid=1.
  - If pend_q != 0: res_hit=1, res_addr = lowest set index of pend_q, res_last=1 iff exactly one bit is set.
  - If pend_q == 0: a single miss beat with res_hit=0, res_addr=0, res_last=1.
- Beat handshake:
  - A beat transfers when res_valid && res_ready.
  - On transfer, the reported bit of pend_q is cleared. If res_last, go to IDLE; otherwise stay in EMIT with the next lowest index on the following cycle.
  - res_addr, res_hit and res_last are stable while res_valid=1 && res_ready=0.
- Throughput: one beat per cycle under continuous res_ready. A lookup with N matches occupies 3+N cycles, plus 1 for a miss.
- Result outputs are combinational from state and pend_q: res_valid=0 outside EMIT. No new request is accepted until the last beat transfers.
- abort (any state):
  - Next state is IDLE and pend_q is cleared.
  - Abort in IDLE blocks acceptance.
  - Abort coincident with a res beat handshake: that beat counts as consumed and no further beats are sent.
  - Abort during SEARCH: the search strobe still fires that cycle, and the returned match vector is ignored.
- rst mid-lookup behaves like abort and also clears key_q.
- All-rows-match (pend_q all ones): emits DEPTH beats, addresses 0..DEPTH-1, with res_last on address DEPTH-1.

Decomposition:
- Shared package bcam_pkg: state enum (IDLE, SEARCH, CAPTURE, EMIT) and the WIDTH/DEPTH/ADDR_W defaults, shared with the array top.
- Sub-module bcam_prio_enc: combinational lowest-set-bit encoder with inputs vec[DEPTH] and outputs idx[ADDR_W], any, one_hot_or_zero. The one_hot_or_zero output is used for res_last.

Test Plan (DEPTH=16, WIDTH=8, CAM stub returns a programmed vector one cycle after the strobe):
- Reset release, then req_key=0xA5 with vector 0x0010 -> cam_search_en pulse at T+1 with key 0xA5; at T+3 one beat: addr=4, hit=1, last=1; req_ready=1 the next cycle.
- Vector 0x8005 with res_ready held 1 -> beats addr 0, 2, 15 on consecutive cycles; last only on 15.
- Vector 0x0000 -> single beat with hit=0, addr=0, last=1.
- Vector 0x0006 with res_ready low for 3 cycles -> addr=1 held stable while stalled; then addr 1 then 2 after release.
- Vector 0xFFFF, abort asserted during the 3rd beat handshake -> beats 0, 1, 2 transfer, res_valid=0 next cycle, state IDLE; a new request is accepted the following cycle.
- rst pulsed in CAPTURE -> all outputs at reset values the next cycle; the subsequent lookup returns correct results with no stale bits.
